// File: rtl/pong_pkg.sv
// Shared Pong types: paddle direction, screen coordinates and RGB byte order.
package pong_pkg;

   typedef enum logic [1:0] {
      DIR_PUT   = 2'b00,
      DIR_LEFT  = 2'b01,
      DIR_RIGHT = 2'b10
   } dir_t;

   typedef logic signed [11:0] coord_t;
   typedef logic signed [12:0] wcoord_t;

   localparam int unsigned RGB_R = 2;
   localparam int unsigned RGB_G = 1;
   localparam int unsigned RGB_B = 0;

   function automatic wcoord_t widen(input coord_t c);
      return {c[11], c};
   endfunction

endpackage

// File: rtl/btn_sync.sv
// Plain multi-flop synchroniser for asynchronous button inputs; intentionally not reset.
module btn_sync #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             pixel_clk,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] s1_q, s2_q, s3_q;

   always_ff @(posedge pixel_clk) begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
   end

   assign q_o = s3_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Pong paddle: per-frame direction/velocity/position update with edge clamping,
// plus raster hit test and fill colour for the compositor.
module paddle_ctrl
   import pong_pkg::*;
#(
   parameter int          HRES     = 1280,
   parameter int          VRES     = 720,
   parameter int          PADDLE_W = 200,
   parameter int          PADDLE_H = 20,
   parameter int          PADDLE_Y = 0,
   parameter int          VEL_MIN  = 4,
   parameter int          VEL_MAX  = 16,
   parameter int          ACCEL    = 4,
   parameter int          DEADBAND = 8,
   parameter logic [23:0] COLOR    = 24'hEFE62E
) (
   input  logic               pixel_clk,
   input  logic               rst,
   input  logic               fsync,
   input  logic signed [11:0] hpos,
   input  logic signed [11:0] vpos,
   input  logic               right,
   input  logic               left,
   input  logic               auto_en,
   input  logic signed [11:0] ball_x,
   output logic        [7:0]  pixel [0:2],
   output logic               active,
   output logic signed [11:0] paddle_l,
   output logic signed [11:0] paddle_r,
   output logic               moving
);

   localparam wcoord_t X_MAX   = wcoord_t'(HRES - PADDLE_W);
   localparam wcoord_t X_RST   = wcoord_t'((HRES - PADDLE_W) / 2);
   localparam wcoord_t HALF_W  = wcoord_t'(PADDLE_W / 2);
   localparam wcoord_t W_M1    = wcoord_t'(PADDLE_W - 1);
   localparam wcoord_t DB      = wcoord_t'(DEADBAND);
   localparam wcoord_t V_MIN   = wcoord_t'(VEL_MIN);
   localparam wcoord_t V_MAX   = wcoord_t'(VEL_MAX);
   localparam wcoord_t V_ACC   = wcoord_t'(ACCEL);
   localparam coord_t  Y_TOP   = coord_t'(PADDLE_Y);
   localparam coord_t  Y_BOT   = coord_t'(PADDLE_Y + PADDLE_H - 1);

   logic right_s, left_s;

   btn_sync #(.WIDTH(1)) u_sync_right (
      .pixel_clk (pixel_clk),
      .d_i       (right),
      .q_o       (right_s)
   );

   btn_sync #(.WIDTH(1)) u_sync_left (
      .pixel_clk (pixel_clk),
      .d_i       (left),
      .q_o       (left_s)
   );

   dir_t    req_q, req_d;
   dir_t    dir_q, dir_d;
   wcoord_t vel_q, vel_d;
   wcoord_t x_q, x_d;
   coord_t  paddle_r_q, paddle_r_d;
   logic    moving_q, moving_d;

   wcoord_t centre, x_step, vel_up, ball_w;

   always_comb begin
      req_d  = req_q;
      dir_d  = dir_q;
      vel_d  = vel_q;
      x_d    = x_q;
      ball_w = widen(ball_x);
      centre = x_q + HALF_W;
      x_step = x_q + vel_q;
      vel_up = vel_q + V_ACC;

      if (fsync) begin
         // Requests are consumed here; synchronised samples in this cycle are dropped.
         req_d = DIR_PUT;
         if (auto_en) begin
            if (ball_w < centre - DB) begin
               dir_d = DIR_LEFT;
            end else if (ball_w > centre + DB) begin
               dir_d = DIR_RIGHT;
            end else begin
               dir_d = DIR_PUT;
            end
         end else begin
            dir_d = req_q;
         end

         if ((dir_d == dir_q) && (dir_d != DIR_PUT)) begin
            vel_d = (vel_up > V_MAX) ? V_MAX : vel_up;
         end else begin
            vel_d = V_MIN;
         end

         // Position moves on the previous frame's direction, so motion lags by one frame.
         case (dir_q)
            DIR_RIGHT: x_d = (x_step > X_MAX) ? X_MAX : x_step;
            DIR_LEFT:  x_d = (x_q < vel_q) ? 13'sd0 : x_q - vel_q;
            default:   x_d = x_q;
         endcase
      end else if (req_q == DIR_PUT) begin
         if (right_s) begin
            req_d = DIR_RIGHT;
         end else if (left_s) begin
            req_d = DIR_LEFT;
         end
      end

      paddle_r_d = coord_t'(x_d + W_M1);
      moving_d   = (dir_d != DIR_PUT);
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         req_q      <= DIR_PUT;
         dir_q      <= DIR_PUT;
         vel_q      <= V_MIN;
         x_q        <= X_RST;
         paddle_r_q <= coord_t'(X_RST + W_M1);
         moving_q   <= 1'b0;
      end else begin
         req_q      <= req_d;
         dir_q      <= dir_d;
         vel_q      <= vel_d;
         x_q        <= x_d;
         paddle_r_q <= paddle_r_d;
         moving_q   <= moving_d;
      end
   end

   assign paddle_l = coord_t'(x_q);
   assign paddle_r = paddle_r_q;
   assign moving   = moving_q;

   always_comb begin
      active = (hpos >= paddle_l) && (hpos <= paddle_r) &&
               (vpos >= Y_TOP) && (vpos <= Y_BOT);
      pixel[RGB_R] = active ? COLOR[23:16] : 8'h00;
      pixel[RGB_G] = active ? COLOR[15:8]  : 8'h00;
      pixel[RGB_B] = active ? COLOR[7:0]   : 8'h00;
   end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: stimulus queues expected paddle state per fsync/probe,
// a monitor pops and compares on the following falling edge.
module tb_paddle_ctrl;

   localparam int FRAME_IDLE = 7;
   localparam logic [23:0] FILL = 24'hEFE62E;

   logic               pixel_clk = 1'b0;
   logic               rst = 1'b0;
   logic               fsync = 1'b0;
   logic signed [11:0] hpos = 12'sd0;
   logic signed [11:0] vpos = 12'sd100;
   logic               right = 1'b0;
   logic               left = 1'b0;
   logic               auto_en = 1'b0;
   logic signed [11:0] ball_x = 12'sd0;
   logic        [7:0]  pixel [0:2];
   logic               active;
   logic signed [11:0] paddle_l;
   logic signed [11:0] paddle_r;
   logic               moving;

   paddle_ctrl dut (
      .pixel_clk (pixel_clk),
      .rst       (rst),
      .fsync     (fsync),
      .hpos      (hpos),
      .vpos      (vpos),
      .right     (right),
      .left      (left),
      .auto_en   (auto_en),
      .ball_x    (ball_x),
      .pixel     (pixel),
      .active    (active),
      .paddle_l  (paddle_l),
      .paddle_r  (paddle_r),
      .moving    (moving)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct {
      string       name;
      bit          chk;
      int          l;
      bit          mov;
      bit          act;
      logic [23:0] px;
   } exp_t;

   exp_t pos_q[$];
   exp_t pix_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic probe = 1'b0;
   logic evt_q = 1'b0;

   always @(posedge pixel_clk) evt_q <= fsync && !rst;

   always @(negedge pixel_clk) begin
      exp_t e;
      logic [23:0] px_act;
      if (evt_q) begin
         if (pos_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL no_expectation: fsync seen with empty scoreboard at %0t", $time);
         end else begin
            e = pos_q.pop_front();
            if (e.chk) begin
               vectors++;
               if (paddle_l != e.l || paddle_r != e.l + 199 || moving != e.mov) begin
                  miscompares++;
                  $display("FAIL %s: got l=%0d r=%0d mov=%0d, want l=%0d r=%0d mov=%0d",
                           e.name, paddle_l, paddle_r, moving, e.l, e.l + 199, e.mov);
               end
            end
         end
      end
      if (probe) begin
         if (pix_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL no_probe_expectation at %0t", $time);
         end else begin
            e = pix_q.pop_front();
            px_act = {pixel[2], pixel[1], pixel[0]};
            vectors++;
            if (paddle_l != e.l || moving != e.mov || active != e.act || px_act != e.px) begin
               miscompares++;
               $display("FAIL %s: got l=%0d mov=%0d act=%0d px=%06h, want l=%0d mov=%0d act=%0d px=%06h",
                        e.name, paddle_l, moving, active, px_act, e.l, e.mov, e.act, e.px);
            end
         end
      end
   end

   task automatic tick();
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic frame(input int idle, input string nm, input int l, input bit mov);
      exp_t e;
      repeat (idle) tick();
      e.name = nm; e.chk = 1'b1; e.l = l; e.mov = mov; e.act = 1'b0; e.px = 24'h0;
      pos_q.push_back(e);
      fsync = 1'b1;
      tick();
      fsync = 1'b0;
   endtask

   task automatic probe_at(input string nm, input int h, input int v, input int l, input bit mov,
                           input bit act);
      exp_t e;
      hpos = 12'(h);
      vpos = 12'(v);
      e.name = nm; e.chk = 1'b1; e.l = l; e.mov = mov; e.act = act;
      e.px = act ? FILL : 24'h0;
      pix_q.push_back(e);
      probe = 1'b1;
      tick();
      probe = 1'b0;
      vpos = 12'sd100;
   endtask

   // Buttons are released long enough for the synchroniser to drain before reset ends;
   // fsync is raised during reset to confirm reset wins.
   task automatic do_reset();
      right = 1'b0;
      left = 1'b0;
      fsync = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      fsync = 1'b1;
      tick();
      fsync = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      miscompares++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog");
   end

   initial begin
      int xe;
      tick();
      do_reset();

      // Reset position and raster hit test
      probe_at("rst_hit",      540, 0,  540, 1'b0, 1'b1);
      probe_at("rst_right_in", 739, 19, 540, 1'b0, 1'b1);
      probe_at("rst_right_out",741, 0,  540, 1'b0, 1'b0);
      probe_at("rst_left_out", 539, 0,  540, 1'b0, 1'b0);
      probe_at("rst_below",    540, 20, 540, 1'b0, 1'b0);

      // Ramp with right held
      right = 1'b1;
      frame(FRAME_IDLE, "ramp1", 540, 1'b1);
      frame(FRAME_IDLE, "ramp2", 544, 1'b1);
      frame(FRAME_IDLE, "ramp3", 552, 1'b1);
      frame(FRAME_IDLE, "ramp4", 564, 1'b1);
      frame(FRAME_IDLE, "ramp5", 580, 1'b1);
      frame(FRAME_IDLE, "ramp6", 596, 1'b1);

      // Right clamp
      for (int i = 1; i <= 74; i++) begin
         xe = 596 + 16 * i;
         if (xe > 1080) xe = 1080;
         frame(FRAME_IDLE, "right_clamp", xe, 1'b1);
      end

      // Reversal restarts at minimum speed
      repeat (3) tick();
      right = 1'b0;
      left = 1'b1;
      frame(4, "rev_hold", 1080, 1'b1);
      frame(FRAME_IDLE, "rev_dir", 1080, 1'b1);
      frame(FRAME_IDLE, "rev_v4", 1076, 1'b1);
      frame(FRAME_IDLE, "rev_v8", 1068, 1'b1);

      // Left clamp from reset: 500 steps down by 16 to 4, then clamps to 0
      do_reset();
      left = 1'b1;
      frame(FRAME_IDLE, "left1", 540, 1'b1);
      frame(FRAME_IDLE, "left2", 536, 1'b1);
      frame(FRAME_IDLE, "left3", 528, 1'b1);
      frame(FRAME_IDLE, "left4", 516, 1'b1);
      frame(FRAME_IDLE, "left5", 500, 1'b1);
      for (int i = 1; i <= 31; i++) frame(FRAME_IDLE, "left_run", 500 - 16 * i, 1'b1);
      frame(FRAME_IDLE, "left_clamp0", 0, 1'b1);
      frame(FRAME_IDLE, "left_hold0a", 0, 1'b1);
      frame(FRAME_IDLE, "left_hold0b", 0, 1'b1);

      // Single-cycle pulse mid-frame
      do_reset();
      repeat (2) tick();
      left = 1'b1;
      tick();
      left = 1'b0;
      frame(4, "pulse_dir", 540, 1'b1);
      frame(FRAME_IDLE, "pulse_move", 536, 1'b0);

      // Pulse whose synchronised sample lands only in the fsync cycle
      repeat (3) tick();
      left = 1'b1;
      tick();
      left = 1'b0;
      repeat (2) tick();
      frame(0, "fsync_pulse_drop", 536, 1'b0);
      frame(FRAME_IDLE, "fsync_pulse_hold", 536, 1'b0);

      // Both buttons in one cycle: right wins
      repeat (2) tick();
      right = 1'b1;
      left = 1'b1;
      tick();
      right = 1'b0;
      left = 1'b0;
      frame(4, "both_dir", 536, 1'b1);
      frame(FRAME_IDLE, "both_move", 540, 1'b0);

      // Auto tracking
      do_reset();
      auto_en = 1'b1;
      ball_x = 12'sd100;
      frame(FRAME_IDLE, "auto_left", 540, 1'b1);
      ball_x = 12'sd645;
      frame(FRAME_IDLE, "auto_put", 536, 1'b0);
      ball_x = 12'sd700;
      frame(FRAME_IDLE, "auto_right", 536, 1'b1);
      frame(FRAME_IDLE, "auto_v4", 540, 1'b1);
      frame(FRAME_IDLE, "auto_v8", 548, 1'b1);

      // Reset mid-motion clears velocity
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      probe_at("rst_mid", 540, 0, 540, 1'b0, 1'b1);
      frame(5, "auto_restart", 540, 1'b1);
      frame(FRAME_IDLE, "auto_vmin", 544, 1'b1);
      frame(FRAME_IDLE, "auto_v8b", 552, 1'b1);

      // Back to manual with no buttons
      auto_en = 1'b0;
      frame(FRAME_IDLE, "manual_put", 564, 1'b0);
      frame(FRAME_IDLE, "manual_hold", 564, 1'b0);

      repeat (3) tick();
      if (pos_q.size() != 0 || pix_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: got %0d/%0d pending entries, want 0/0", pos_q.size(), pix_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Second-generation Pong paddle. It takes button or auto-tracking requests and moves the paddle once per frame. Speed ramps while a direction is held. Position is clamped to the screen edges, and the paddle row is set by a parameter, so one module serves both players. The block sits beside the ball object under the HDMI pixel mux: it feeds `pixel`/`active` to the compositor and `paddle_l`/`paddle_r` to ball collision logic.

## Interface
- `HRES`, 1280: horizontal resolution in pixels
- `VRES`, 720: vertical resolution; the paddle must satisfy `PADDLE_Y + PADDLE_H <= VRES`
- `PADDLE_W`, 200: width in pixels
- `PADDLE_H`, 20: height in pixels
- `PADDLE_Y`, 0: top row of the paddle (0 = top player, `VRES-PADDLE_H` = bottom player)
- `VEL_MIN`, 4: speed in pixels/frame on the first moving frame
- `VEL_MAX`, 16: speed ceiling in pixels/frame
- `ACCEL`, 4: speed increment per frame while the same direction is held
- `DEADBAND`, 8: auto-mode tolerance around the paddle centre, in pixels
- `COLOR`, 24'hEFE62E: RGB fill colour
- `pixel_clk`  in  1  pixel clock
- `rst`  in  1  reset: synchronous, active-high; clock `pixel_clk`
- `fsync`  in  1  one-cycle frame-start pulse
- `hpos`, `vpos`  in  12 signed  current raster position
- `right`, `left`  in  1 each  asynchronous buttons
- `auto_en`  in  1  1 = track `ball_x` instead of using the buttons; sampled only at `fsync`
- `ball_x`  in  12 signed  ball centre column
- `pixel[0:2]`  out  8 each  [2]=R, [1]=G, [0]=B
- `active`  out  1  raster position is inside the paddle
- `paddle_l`, `paddle_r`  out  12 signed  registered left column and right column of the paddle (inclusive)
- `moving`  out  1  registered; 1 when the current direction is not PUT

## Operation
- **Button synchronisation:** `right` and `left` each pass through a 3-flop synchroniser. The synchroniser flops are not reset.
- **Request capture (non-fsync cycles):**
  - If no request is pending, the first synchronised button seen sets a sticky request.
  - If both buttons are seen in the same cycle, RIGHT wins.
  - A pending request ignores later button activity until the next `fsync`.
- **Direction FSM (`dir`):** states PUT, LEFT, RIGHT. It updates only on `fsync` cycles:
  - if `auto_en`=1: `c = x + PADDLE_W/2`; `ball_x < c-DEADBAND` gives LEFT, `ball_x > c+DEADBAND` gives RIGHT, otherwise PUT;
  - if `auto_en`=0: pending RIGHT gives RIGHT, pending LEFT gives LEFT, otherwise PUT;
  - pending requests are cleared on every `fsync`, and button samples taken in the `fsync` cycle are discarded.
- **Velocity (`vel`):** updates on `fsync` together with `dir`.
  - If the new `dir` equals the old `dir` and is not PUT: `vel <= min(vel+ACCEL, VEL_MAX)`.
  - Otherwise `vel <= VEL_MIN`. This covers reversal, release and start of motion.
- **Position (`x`):** updates on `fsync` using the *old* `dir` and `vel`, so motion lags a request by one frame.
  - Arithmetic is 13-bit signed.
  - RIGHT: `x <= min(x+vel, HRES-PADDLE_W)`.
  - LEFT: `x <= (x < vel) ? 0 : x-vel`.
  - PUT: `x` is held.
- **Outputs:**
  - `paddle_l = x`, `paddle_r = x + PADDLE_W - 1`, `moving = (dir != PUT)`; all registered.
  - `active` (combinational) = `paddle_l <= hpos <= paddle_r && PADDLE_Y <= vpos <= PADDLE_Y+PADDLE_H-1`.
  - `pixel` = `COLOR` bytes when `active`, otherwise 0.

## Timing
- **Reset values:**
  - `x = (HRES-PADDLE_W)/2`, so `paddle_l`=540 and `paddle_r`=739 at defaults;
  - `dir` = PUT, `vel` = VEL_MIN, pending requests cleared, `moving` = 0;
  - `active`/`pixel` follow `hpos`/`vpos` against the reset position.
- **Latency:**
  - button edge to pending request: 3 cycles;
  - pending request to `dir` change: at the next `fsync`;
  - `dir` change to first position change: at the following `fsync`.
- **`fsync` during reset:** `rst` has priority over `fsync`.
- **Reset mid-motion:** returns to the reset state in one cycle; no residual velocity.
- **Held buttons:** a held button re-registers immediately after each `fsync`, so held motion is continuous.
- **Mode switch:** changing `auto_en` between frames takes effect at the next `fsync` with no glitch. `vel` resets if the resulting `dir` differs from the old one.

## Structure
- The shared package `pong_pkg` holds:
  - `dir_t` enum: `DIR_PUT`=2'b00, `DIR_LEFT`=2'b01, `DIR_RIGHT`=2'b10;
  - coordinate typedef `coord_t` (logic signed [11:0]);
  - RGB byte-order constants.
- Sub-module `btn_sync` (3-flop synchroniser, width parameter): one instance per button.

## Test plan
Defaults apply unless stated (reset position `x` = 540, `PADDLE_Y` = 0).
- **Reset:** `rst` high for 2 cycles -> `paddle_l`=540, `paddle_r`=739, `moving`=0; (`hpos`,`vpos`)=(540,0) gives `active`=1 and `pixel`={EF,E6,2E}; (741,0) or (540,20) gives `active`=0 and `pixel`=0.
- **Ramp:** hold `right` from reset across fsyncs 1-6 -> `x` after each = 540, 544, 552, 564, 580, 596 (`vel` saturates at 16).
- **Right clamp:** hold `right` for 80 frames -> `x` stops at 1080, `paddle_r`=1279, never exceeds; then press `left` -> the next step uses `vel`=4.
- **Left clamp / single pulse:** with `x`=2 and `dir`=LEFT, next `fsync` -> `x`=0. A 1-cycle `left` pulse mid-frame still produces LEFT at the next `fsync`; a pulse in the `fsync` cycle alone is discarded.
- **Both buttons:** `right` and `left` asserted in the same cycle -> `dir`=RIGHT.
- **Auto mode / reset mid-motion:**
  - `auto_en`=1, `x`=540, `ball_x`=100 -> LEFT; `ball_x`=645 -> PUT; `ball_x`=700 -> RIGHT.
  - `rst` during auto motion -> `x`=540 and `vel`=4 on the next cycle.
